// File: rtl/fact_ctrl.sv
// Control unit for the factorial datapath: request/response handshakes around dp init/done sequencing.
// Optional RUN-state watchdog enabled by defining FACT_CTRL_TIMEOUT_EN.
module fact_ctrl #(
  parameter int SIZE        = 8,
  parameter int MAX_N       = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] n_in,
  output logic            ready,
  output logic [SIZE-1:0] n_out,
  output logic            init,
  output logic            done,
  input  logic            proceed,
  input  logic [SIZE-1:0] dp_result,
  output logic            res_valid,
  output logic [SIZE-1:0] res_data,
  output logic            err,
  input  logic            res_ack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    FIN    = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [SIZE-1:0] MAX_N_V = SIZE'(MAX_N);
  localparam logic [SIZE-1:0] ONE_V   = SIZE'(1);

  state_t state;

  assign ready = (state == IDLE);

`ifdef FACT_CTRL_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] run_cnt;
  logic             timed_out;

  // Counter holds zero outside RUN, so it starts from zero on every RUN entry.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      run_cnt <= '0;
    end else if (run_cnt != CNT_MAX) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // True during the TIMEOUT_CYC-th RUN cycle.
  assign timed_out = (run_cnt == CNT_LAST);
`else
  // Watchdog absent: TIMEOUT_CYC only shapes this empty elaboration-time guard.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_out     <= '0;
      res_data  <= '0;
      init      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_out <= n_in;
            if (n_in <= ONE_V) begin
              state     <= RESP;
              res_valid <= 1'b1;
              res_data  <= ONE_V;
              err       <= 1'b0;
            end else if (n_in > MAX_N_V) begin
              state     <= RESP;
              res_valid <= 1'b1;
              res_data  <= '0;
              err       <= 1'b1;
            end else begin
              state <= LOAD;
              init  <= 1'b1;
            end
          end
        end
        LOAD: begin
          init  <= 1'b0;
          state <= SETTLE;
        end
        SETTLE: begin
          state <= RUN;
        end
        RUN: begin
          if (!proceed) begin
            done  <= 1'b1;
            state <= FIN;
          end
`ifdef FACT_CTRL_TIMEOUT_EN
          else if (timed_out) begin
            state     <= RESP;
            res_valid <= 1'b1;
            res_data  <= '0;
            err       <= 1'b1;
          end
`endif
        end
        FIN: begin
          done      <= 1'b0;
          res_data  <= dp_result;
          err       <= 1'b0;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl with a small behavioural factorial datapath and a factorial reference model.
module tb_fact_ctrl;

  localparam int SIZE        = 8;
  localparam int MAX_N       = 5;
  localparam int TIMEOUT_CYC = 64;
  localparam int LIMIT       = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] n_in;
  logic            ready;
  logic [SIZE-1:0] n_out;
  logic            init;
  logic            done;
  logic            proceed;
  logic [SIZE-1:0] dp_result;
  logic            res_valid;
  logic [SIZE-1:0] res_data;
  logic            err;
  logic            res_ack;
  logic            force_hi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fact_ctrl #(.SIZE(SIZE), .MAX_N(MAX_N), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .ready(ready),
    .n_out(n_out), .init(init), .done(done), .proceed(proceed),
    .dp_result(dp_result), .res_valid(res_valid), .res_data(res_data),
    .err(err), .res_ack(res_ack)
  );

  // Behavioural dp: multiplies down from n, proceed while more factors remain.
  logic [SIZE-1:0] dp_cnt, dp_acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_cnt <= '0;
      dp_acc <= '0;
    end else if (init) begin
      dp_cnt <= n_out;
      dp_acc <= 1;
    end else if (dp_cnt > 1) begin
      dp_acc <= dp_acc * dp_cnt;
      dp_cnt <= dp_cnt - 1'b1;
    end
  end
  assign proceed   = (dp_cnt > 1) | force_hi;
  assign dp_result = dp_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request/response transaction checked against the reference model.
  task automatic do_req(input int n, input int ack_delay, input bit to_exp, input string tag);
    int t, init_cnt, done_cnt, init_t, done_t, exp_lat, w;
    bit got, overlap, nchg, unstable;
    logic [SIZE-1:0] exp_d, hold_d;
    logic exp_e;
    int prod;
    if (to_exp) begin
      exp_d = 0; exp_e = 1; exp_lat = TIMEOUT_CYC + 2;
    end else if (n <= 1) begin
      exp_d = 1; exp_e = 0; exp_lat = 0;
    end else if (n > MAX_N) begin
      exp_d = 0; exp_e = 1; exp_lat = 0;
    end else begin
      prod = 1;
      for (int k = 2; k <= n; k++) prod = prod * k;
      exp_d = SIZE'(prod); exp_e = 0; exp_lat = n + 2;
    end

    w = 0;
    while (ready !== 1'b1 && w < LIMIT) begin tick(); w++; end
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL %s ready_before: got %b expected 1", tag, ready); end

    start = 1'b1; n_in = SIZE'(n);
    tick();
    start = 1'b0; n_in = SIZE'($urandom);
    t = 0; got = 0; init_cnt = 0; done_cnt = 0; init_t = -1; done_t = -1;
    overlap = 0; nchg = 0;
    while (t < LIMIT) begin
      if (init === 1'b1) begin init_cnt++; init_t = t; end
      if (done === 1'b1) begin done_cnt++; done_t = t; end
      if (init === 1'b1 && done === 1'b1) overlap = 1;
      if (n_out !== SIZE'(n)) nchg = 1;
      if (res_valid === 1'b1) begin got = 1; break; end
      start   = ($urandom % 3) == 0;
      n_in    = SIZE'($urandom);
      res_ack = ($urandom % 3) == 0;
      tick();
      t++;
    end
    start = 1'b0; res_ack = 1'b0;

    n_cmp++;
    if (!got || t != exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d (valid=%0b) expected %0d", tag, t, got, exp_lat); end
    n_cmp++;
    if (res_data !== exp_d) begin n_bad++; $display("FAIL %s res_data: got %0d expected %0d", tag, res_data, exp_d); end
    n_cmp++;
    if (err !== exp_e) begin n_bad++; $display("FAIL %s err: got %b expected %b", tag, err, exp_e); end
    n_cmp++;
    if (exp_lat == 0 || to_exp) begin
      if (init_cnt != (to_exp ? 1 : 0)) begin n_bad++; $display("FAIL %s init_count: got %0d expected %0d", tag, init_cnt, to_exp ? 1 : 0); end
    end else if (init_cnt != 1 || init_t != 0) begin
      n_bad++; $display("FAIL %s init_pulse: got count %0d at %0d expected 1 at 0", tag, init_cnt, init_t);
    end
    n_cmp++;
    if (exp_lat == 0 || to_exp) begin
      if (done_cnt != 0) begin n_bad++; $display("FAIL %s done_count: got %0d expected 0", tag, done_cnt); end
    end else if (done_cnt != 1 || done_t != exp_lat - 1) begin
      n_bad++; $display("FAIL %s done_pulse: got count %0d at %0d expected 1 at %0d", tag, done_cnt, done_t, exp_lat - 1);
    end
    n_cmp++;
    if (overlap || nchg) begin n_bad++; $display("FAIL %s overlap_or_nout: got overlap=%0b nout_changed=%0b expected 0/0", tag, overlap, nchg); end

    // Consumer holds off ack; response must not move meanwhile.
    hold_d = res_data; unstable = 0;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== hold_d || err !== exp_e || done !== 1'b0 || n_out !== SIZE'(n)) unstable = 1;
    end
    n_cmp++;
    if (unstable) begin n_bad++; $display("FAIL %s hold_stable: got unstable response expected stable for %0d cycles", tag, ack_delay); end

    // Ack together with a start that must be ignored.
    res_ack = 1'b1; start = 1'b1; n_in = SIZE'($urandom_range(2, MAX_N));
    tick();
    res_ack = 1'b0; start = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0 || init !== 1'b0) begin
      n_bad++; $display("FAIL %s resp_exit: got ready=%b valid=%b err=%b init=%b expected 1/0/0/0", tag, ready, res_valid, err, init);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || init !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0 || n_out !== '0 || res_data !== '0) begin
      n_bad++; $display("FAIL reset_state: got ready=%b init=%b done=%b valid=%b err=%b n_out=%0d res=%0d expected 1/0/0/0/0/0/0",
                        ready, init, done, res_valid, err, n_out, res_data);
    end
  endtask

  task automatic test_fact();
    do_req(5, 1, 0, "fact5");
    do_req(3, 1, 0, "fact3_b2b");
    for (int i = 0; i < 6; i++) do_req($urandom_range(2, MAX_N), 1, 0, "fact_rand");
  endtask

  task automatic test_trivial();
    do_req(0, 1, 0, "trivial0");
    do_req(1, 1, 0, "trivial1");
  endtask

  task automatic test_err();
    do_req(6, 1, 0, "err6");
    do_req(255, 1, 0, "err255");
    for (int i = 0; i < 3; i++) do_req($urandom_range(MAX_N + 1, 255), 1, 0, "err_rand");
  endtask

  task automatic test_reset_mid_run();
    bit leaked;
    start = 1'b1; n_in = 5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || res_valid !== 1'b0 || init !== 1'b0 || done !== 1'b0 || err !== 1'b0 || n_out !== '0) begin
      n_bad++; $display("FAIL midrun_reset: got ready=%b valid=%b init=%b done=%b err=%b n_out=%0d expected 1/0/0/0/0/0",
                        ready, res_valid, init, done, err, n_out);
    end
    leaked = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) leaked = 1;
    end
    n_cmp++;
    if (leaked) begin n_bad++; $display("FAIL midrun_no_response: got activity after reset expected idle"); end
    do_req(4, 1, 0, "after_reset4");
  endtask

  task automatic test_ack_holdoff();
    do_req($urandom_range(2, MAX_N), 5, 0, "holdoff_fact");
    do_req($urandom_range(MAX_N + 1, 255), 5, 0, "holdoff_err");
  endtask

`ifdef FACT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    force_hi = 1'b1;
    do_req(5, 5, 1, "timeout");
    force_hi = 1'b0;
    do_req(3, 1, 0, "after_timeout3");
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; n_in = '0; res_ack = 1'b0; force_hi = 1'b0;
    test_reset();
    test_fact();
    test_trivial();
    test_err();
    test_reset_mid_run();
    test_ack_holdoff();
`ifdef FACT_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
